// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of a 4-channel TDM serial link.
// Deserialises a 1-bit stream (slot 0 first, MSB first, fs on the frame's first bit)
// and publishes all four channel words together once per good frame.
// Optional feature macro: TDM_PARITY_EN adds one even-parity bit after slot 3.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             fs,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_vld,
    output logic             locked,
    output logic             sync_err,
    output logic             par_err
);

    localparam logic [0:0] STATE_HUNT = 1'b0;
    localparam logic [0:0] STATE_LOCK = 1'b1;

    localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

    // Bit position within the frame is kept as (slot, bit-in-slot); slot 4 is the parity bit.
    logic [0:0]       r_state;
    logic [2:0]       r_slot;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold [4];

    logic [WIDTH-1:0] w_word;
    logic             w_pos0;
    logic             w_slot_end;
    logic             w_frame_end;

    // Decode the current bit position and assemble the word completed by this sample.
    always_comb begin
        w_word     = {r_shift[WIDTH-2:0], din};
        w_pos0     = (r_slot == 3'd0) && (r_bit == '0);
        w_slot_end = (r_bit == BIT_LAST);
`ifdef TDM_PARITY_EN
        w_frame_end = (r_slot == 3'd4);
`else
        w_frame_end = (r_slot == 3'd3) && w_slot_end;
`endif
    end

`ifdef TDM_PARITY_EN
    // Running XOR of the frame's bits; restarts on the bit taken as pos 0.
    logic r_par;
    logic w_par_ok;
    assign w_par_ok = ((r_par ^ din) == 1'b0);
`else
    assign par_err = 1'b0;
`endif

    // Alignment FSM, bit counters, shift register and output registers.
    // NOTE: every register here uses non-blocking assignment so all updates read pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= STATE_HUNT;
            r_slot    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            // NOTE: the holding registers are cleared too; cheap at four words and keeps y deterministic.
            for (int k = 0; k < 4; k++) r_hold[k] <= '0;
            y0        <= '0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
            frame_vld <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
`ifdef TDM_PARITY_EN
            r_par     <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err   <= 1'b0;
`endif
            if (en) begin
                if ((r_state == STATE_HUNT && fs) || (r_state == STATE_LOCK && fs && !w_pos0)) begin
                    // First fs, or early fs while locked: this bit is pos 0 of a new frame.
                    sync_err <= (r_state == STATE_LOCK);
                    r_state  <= STATE_LOCK;
                    locked   <= 1'b1;
                    r_shift  <= w_word;
                    r_slot   <= '0;
                    r_bit    <= BW'(1);
`ifdef TDM_PARITY_EN
                    r_par    <= din;
`endif
                end else if (r_state == STATE_LOCK && !fs && w_pos0) begin
                    // Missing fs where a frame should start: drop the bit and hunt again.
                    sync_err <= 1'b1;
                    r_state  <= STATE_HUNT;
                    locked   <= 1'b0;
                end else if (r_state == STATE_LOCK) begin
                    r_shift <= w_word;
`ifdef TDM_PARITY_EN
                    r_par   <= w_pos0 ? din : (r_par ^ din);
`endif
                    if (w_slot_end) r_hold[r_slot[1:0]] <= w_word;

                    if (w_frame_end) begin
                        r_slot <= '0;
                        r_bit  <= '0;
`ifdef TDM_PARITY_EN
                        if (w_par_ok) begin
                            y0        <= r_hold[0];
                            y1        <= r_hold[1];
                            y2        <= r_hold[2];
                            y3        <= r_hold[3];
                            frame_vld <= 1'b1;
                        end else begin
                            par_err   <= 1'b1;
                        end
`else
                        y0        <= r_hold[0];
                        y1        <= r_hold[1];
                        y2        <= r_hold[2];
                        y3        <= w_word;
                        frame_vld <= 1'b1;
`endif
                    end else if (w_slot_end) begin
                        r_slot <= r_slot + 3'd1;
                        r_bit  <= '0;
                    end else begin
                        r_bit  <= r_bit + BW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: directed bench for tdm_demux_4ch with WIDTH=8.
// Builds with or without TDM_PARITY_EN; the parity frame test runs only when it is defined.
module tb_tdm_demux_4ch;

`ifdef TDM_PARITY_EN
    localparam int FL = 33;
`else
    localparam int FL = 32;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       din = 1'b0;
    logic       fs  = 1'b0;
    logic [7:0] y0, y1, y2, y3;
    logic       frame_vld, locked, sync_err, par_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-send observations
    int   n_vld, n_serr, n_perr, bad_gap;
    logic vld_last, locked_first;

    tdm_demux_4ch #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .fs(fs),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .frame_vld(frame_vld), .locked(locked), .sync_err(sync_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; din = 1'b0; fs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Send nbits of a frame, MSB first; bit index 32 is the parity bit (good or bad).
    // fs is raised on bit fs_at (-1: never). gap en=0 cycles follow every strobed bit.
    task automatic send(input logic [31:0] data, input int nbits, input int fs_at,
                        input logic par_good, input int gap);
        logic        b;
        logic [31:0] snap;
        n_vld = 0; n_serr = 0; n_perr = 0; bad_gap = 0;
        vld_last = 1'b0; locked_first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) b = data[31-i];
            else        b = par_good ? ^data : ~^data;
            en = 1'b1; din = b; fs = (i == fs_at);
            @(posedge clk); #1;
            if (frame_vld) begin
                n_vld++;
                vld_last = (i == nbits - 1);
            end
            if (sync_err) n_serr++;
            if (par_err)  n_perr++;
            if (i == 0) locked_first = locked;
            en = 1'b0; din = 1'b0; fs = 1'b0;
            snap = {y0, y1, y2, y3};
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                if (frame_vld || sync_err || par_err || ({y0, y1, y2, y3} !== snap)) bad_gap++;
            end
        end
        en = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_y",      {y0, y1, y2, y3}, 32'h0);
        chk("rst_locked", {31'b0, locked}, 32'd0);
        chk("rst_vld",    {31'b0, frame_vld}, 32'd0);
        chk("rst_serr",   {31'b0, sync_err}, 32'd0);
        chk("rst_perr",   {31'b0, par_err}, 32'd0);

        // 1: continuous strobe, good frame
        send(32'hA53CFF01, FL, 0, 1'b1, 0);
        chk("t1_locked_first", {31'b0, locked_first}, 32'd1);
        chk("t1_y",        {y0, y1, y2, y3}, 32'hA53CFF01);
        chk("t1_nvld",     n_vld, 1);
        chk("t1_vld_last", {31'b0, vld_last}, 32'd1);
        chk("t1_serr",     n_serr, 0);
        @(posedge clk); #1;
        chk("t1_vld_1cyc", {31'b0, frame_vld}, 32'd0);

        // 2: en high every third cycle
        do_reset();
        send(32'hA53CFF01, FL, 0, 1'b1, 2);
        chk("t2_y",        {y0, y1, y2, y3}, 32'hA53CFF01);
        chk("t2_nvld",     n_vld, 1);
        chk("t2_vld_last", {31'b0, vld_last}, 32'd1);
        chk("t2_gap",      bad_gap, 0);

        // 3: missing fs at pos 0, then relock
        send(32'h11223344, FL, -1, 1'b1, 0);
        chk("t3_serr",   n_serr, 1);
        chk("t3_nvld",   n_vld, 0);
        chk("t3_locked", {31'b0, locked}, 32'd0);
        chk("t3_y_hold", {y0, y1, y2, y3}, 32'hA53CFF01);
        send(32'h12345678, FL, 0, 1'b1, 0);
        chk("t3_relock", {31'b0, locked}, 32'd1);
        chk("t3_y_new",  {y0, y1, y2, y3}, 32'h12345678);
        chk("t3_nvld2",  n_vld, 1);

        // 4: early fs at bit 3 of slot 2 (pos 19)
        send(32'hDEADBEEF, 19, 0, 1'b1, 0);
        chk("t4_partial_nvld", n_vld, 0);
        send(32'h5AC3007E, FL, 0, 1'b1, 0);
        chk("t4_serr",   n_serr, 1);
        chk("t4_nvld",   n_vld, 1);
        chk("t4_y",      {y0, y1, y2, y3}, 32'h5AC3007E);
        chk("t4_locked", {31'b0, locked}, 32'd1);

        // fs on the final bit: early sync, no update for the cut frame
        send(32'hCAFEBABE, FL - 1, 0, 1'b1, 0);
        chk("fin_partial_nvld", n_vld, 0);
        send(32'h0F0F0F0F, FL, 0, 1'b1, 0);
        chk("fin_serr",  n_serr, 1);
        chk("fin_nvld",  n_vld, 1);
        chk("fin_y",     {y0, y1, y2, y3}, 32'h0F0F0F0F);

        // 5: reset mid-slot 1
        send(32'h99887766, 12, 0, 1'b1, 0);
        do_reset();
        chk("t5_y",      {y0, y1, y2, y3}, 32'h0);
        chk("t5_locked", {31'b0, locked}, 32'd0);
        chk("t5_vld",    {31'b0, frame_vld}, 32'd0);
        send(32'hFFFFFFFF, 10, -1, 1'b1, 0);
        chk("t5_hunt_locked", {31'b0, locked}, 32'd0);
        chk("t5_hunt_nvld",   n_vld, 0);
        chk("t5_hunt_serr",   n_serr, 0);
        send(32'hC0FFEE11, FL, 0, 1'b1, 0);
        chk("t5_y_new",  {y0, y1, y2, y3}, 32'hC0FFEE11);

`ifdef TDM_PARITY_EN
        // 6: wrong parity, then correct parity
        send(32'hA53CFF01, FL, 0, 1'b0, 0);
        chk("t6_perr",   n_perr, 1);
        chk("t6_nvld",   n_vld, 0);
        chk("t6_y_hold", {y0, y1, y2, y3}, 32'hC0FFEE11);
        chk("t6_locked", {31'b0, locked}, 32'd1);
        send(32'hA53CFF01, FL, 0, 1'b1, 0);
        chk("t6_perr_ok", n_perr, 0);
        chk("t6_nvld_ok", n_vld, 1);
        chk("t6_y_new",   {y0, y1, y2, y3}, 32'hA53CFF01);
`else
        // Without parity the error output never rises
        send(32'hA53CFF01, FL, 0, 1'b1, 0);
        chk("np_perr", n_perr, 0);
        chk("np_y",    {y0, y1, y2, y3}, 32'hA53CFF01);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
